// File: rtl/deser_16_64.sv
// deser_16_64: narrow-to-wide deserializer on a valid/stop link; optional flush via DESER_FLUSH_EN
module deser_16_64 #(
  parameter int INWIDTH  = 16,
  parameter int OUTWIDTH = 64,
  parameter int DEPTH    = OUTWIDTH / INWIDTH
) (
  input  logic                clk,
  input  logic                res,
  input  logic [INWIDTH-1:0]  wdata,
  input  logic                valid_in,
  output logic                stop_out,
  output logic [OUTWIDTH-1:0] rdata,
  output logic                valid_out,
  input  logic                stop_in
`ifdef DESER_FLUSH_EN
  ,
  input  logic                flush
`endif
);
  localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  if (OUTWIDTH % INWIDTH != 0 || DEPTH * INWIDTH != OUTWIDTH) begin : g_chk
    $error("deser_16_64: OUTWIDTH must be DEPTH times INWIDTH");
  end
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUTWIDTH-1:0] coll_q, coll_d, rdata_q, rdata_d, shifted;
  logic                valid_out_q, valid_out_d, acc, last, load, fl;
  assign last      = cnt_q == LAST;
  assign stop_out  = last && valid_out_q && stop_in;
  assign acc       = valid_in && !stop_out;
  assign load      = acc && last;
  assign shifted   = (coll_q << INWIDTH) | OUTWIDTH'(wdata);
  assign rdata     = rdata_q;
  assign valid_out = valid_out_q;
`ifdef DESER_FLUSH_EN
  logic [OUTWIDTH-1:0] part;
  assign fl   = flush && cnt_q != '0 && !acc && (!valid_out_q || !stop_in);
  assign part = coll_q << (INWIDTH * (DEPTH - int'(cnt_q)));
`else
  assign fl = 1'b0;
`endif
  // next state: shift slices in, load on the completing word (or flush), drop valid on drain
  always_comb begin
    coll_d      = acc ? shifted : coll_q;
    cnt_d       = acc ? (last ? '0 : cnt_q + CW'(1)) : (fl ? '0 : cnt_q);
    valid_out_d = load || fl || (valid_out_q && stop_in);
`ifdef DESER_FLUSH_EN
    rdata_d     = load ? shifted : (fl ? part : rdata_q);
`else
    rdata_d     = load ? shifted : rdata_q;
`endif
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q       <= '0;
      coll_q      <= '0;
      rdata_q     <= '0;
      valid_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      coll_q      <= coll_d;
      rdata_q     <= rdata_d;
      valid_out_q <= valid_out_d;
    end
  end
endmodule
